ucode_sequencer: RTL and testbench
==================================

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter MAX_STEPS, default 6, legal range 5..16; step-counter watchdog limit.
REQ-002 Parameter CW_W, default 16, minimum 16; control-word width, and bits above 15 shall be driven 0.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port opcode  input  4  upper nibble of the instruction register.
REQ-006 Port flag_c_i, flag_z_i  input  1 each  carry and zero from the ALU.
REQ-007 Port ctrl  output  CW_W  control word, combinational from step, opcode, flags and halt state.
REQ-008 Port step  output  $clog2(MAX_STEPS)  current microstep.
REQ-009 Port halted  output  1  sticky halt indicator.
REQ-010 Port flags_o  output  2  latched {C,Z}.

Function
REQ-011 Control bit map (bit index: signal): FI15 J14 CO13 CE12 OI11 BI10 SU9 EO8 AI7 AO6 II5 IO4 RI3 RO2 MI1 HLT0.
REQ-012 Fetch is common to all opcodes: step0 = CO|MI; step1 = RO|II|CE.
REQ-013 Execute steps, counting from step2, are as follows; any step not listed is an end-of-instruction step:
- LDA 0x1: IO|MI, RO|AI.
- ADD 0x2: IO|MI, RO|BI, EO|AI|FI.
- SUB 0x3: IO|MI, RO|BI, EO|SU|AI|FI.
- STA 0x4: IO|MI, AO|RI.
- LDI 0x5: IO|AI.
- JMP 0x6: IO|J.
- JC 0x7: IO|J if C=1, else no execute step.
- JZ 0x8: IO|J if Z=1, else no execute step.
- OUT 0xE: AO|OI.
- HLT 0xF: HLT.
- NOP 0x0 and undefined opcodes: no execute steps.
REQ-014 Variable length: on the rising edge at the last active step of an instruction, step shall return to 0, with no dead cycles (LDA=4 cycles, ADD=5, NOP=2).
REQ-015 Watchdog: step shall wrap to 0 after MAX_STEPS-1 regardless of opcode.
REQ-016 A not-taken JC/JZ shall end at step1, giving 2 cycles.
REQ-017 Flags: on a rising edge where ctrl[FI]=1, flags_o shall load {flag_c_i, flag_z_i}; otherwise flags_o holds.
REQ-018 Halt: on the edge leaving step2 of HLT, halted shall set to 1.
REQ-019 While halted=1, step shall freeze at 2 and ctrl shall be 0x0001 until rst.
REQ-020 opcode changes mid-instruction shall take effect combinationally; opcode is sampled only through the current step decode.
REQ-021 Simultaneous FI and step wrap shall both occur on the same edge.

Reset
REQ-022 rst shall force step=0, halted=0 and flags_o=00 immediately, without waiting for a clock edge.
REQ-023 While rst is asserted, ctrl shall equal 0x2002 (step0 decode), including when rst is asserted mid-instruction or while halted.
REQ-024 After rst deasserts, the first rising edge shall advance step from 0 to 1.

Configuration
REQ-025 Macro SEQ_COND_JMP_EN defined: the flags register is present and JC/JZ are conditional per REQ-013.
REQ-026 Macro SEQ_COND_JMP_EN undefined: flag inputs are ignored, flags_o is tied 00, JC/JZ behave as NOP (2 cycles), and ADD/SUB still assert FI.

Structure
REQ-027 A shared package sap_pkg shall hold the bit-index constants, the opcode constants and the 16-bit control-word typedef.
REQ-028 The flags register shall be a sub-module, seq_flags_reg, instantiated only under SEQ_COND_JMP_EN.

Verification
REQ-029 rst high mid-ADD at step3 -> step=0, ctrl=0x2002 and halted=0 with no clock edge required.
REQ-030 Opcode sequence LDA, ADD, OUT -> step sequences 0-3, 0-4, 0-2.
- ADD step4: ctrl=0x8180.
- OUT step2: ctrl=0x0840.
REQ-031 ADD with flag_c_i=1, flag_z_i=0, then JC -> flags_o=10 after ADD step4, and JC step2 ctrl=0x4010.
REQ-032 JZ with Z=0 -> step goes 0,1,0 and the J bit is never asserted.
REQ-033 HLT -> halted=1 after step2, then 10 further clocks keep step=2 and ctrl=0x0001; rst clears halted.
REQ-034 MAX_STEPS=5 with undefined opcode 0x9 -> 2-cycle NOP, step never exceeds 1.
- Without SEQ_COND_JMP_EN: JC with flag_c_i=1 -> 2-cycle NOP and flags_o=00.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: control-word bit indices, opcodes and control-word type for the SAP microsequencer
package sap_pkg;
  localparam int FI = 15, J = 14, CO = 13, CE = 12, OI = 11, BI = 10, SU = 9, EO = 8;
  localparam int AI = 7, AO = 6, II = 5, IO = 4, RI = 3, RO = 2, MI = 1, HLT = 0;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC = 4'h7;
  localparam logic [3:0] OP_JZ = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF;
  typedef logic [15:0] cw_t;
  function automatic cw_t bit_mask(input int i);
    return cw_t'(1) << i;
  endfunction
endpackage

// File: rtl/seq_flags_reg.sv
// seq_flags_reg: {C,Z} flags register loaded when the control word asserts FI
module seq_flags_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] d,
  output logic [1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 2'b00;
    else if (load) q <= d;
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: variable-length SAP microcode sequencer; SEQ_COND_JMP_EN enables flags and JC/JZ
module ucode_sequencer
  import sap_pkg::*;
#(
  parameter int MAX_STEPS = 6,
  parameter int CW_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   opcode,
  input  logic                         flag_c_i,
  input  logic                         flag_z_i,
  output logic [CW_W-1:0]              ctrl,
  output logic [$clog2(MAX_STEPS)-1:0] step,
  output logic                         halted,
  output logic [1:0]                   flags_o
);
  localparam int SW = $clog2(MAX_STEPS);
  localparam cw_t F0 = bit_mask(CO) | bit_mask(MI);
  localparam cw_t F1 = bit_mask(RO) | bit_mask(II) | bit_mask(CE);
  localparam cw_t MAR = bit_mask(IO) | bit_mask(MI);
  localparam cw_t JMP = bit_mask(IO) | bit_mask(J);
  cw_t cw, nxt, e0, e1, e2;
  logic last;
`ifdef SEQ_COND_JMP_EN
  seq_flags_reg u_flags (
    .clk(clk),
    .rst(rst),
    .load(cw[FI]),
    .d({flag_c_i, flag_z_i}),
    .q(flags_o)
  );
`else
  logic unused_flags;
  assign unused_flags = flag_c_i ^ flag_z_i;
  assign flags_o = 2'b00;
`endif
  // An all-zero execute word marks the end of the instruction
  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    case (opcode)
      OP_LDA: begin e0 = MAR; e1 = bit_mask(RO) | bit_mask(AI); end
      OP_ADD: begin e0 = MAR; e1 = bit_mask(RO) | bit_mask(BI); e2 = bit_mask(EO) | bit_mask(AI) | bit_mask(FI); end
      OP_SUB: begin e0 = MAR; e1 = bit_mask(RO) | bit_mask(BI); e2 = bit_mask(EO) | bit_mask(SU) | bit_mask(AI) | bit_mask(FI); end
      OP_STA: begin e0 = MAR; e1 = bit_mask(AO) | bit_mask(RI); end
      OP_LDI: e0 = bit_mask(IO) | bit_mask(AI);
      OP_JMP: e0 = JMP;
      OP_JC:  e0 = flags_o[1] ? JMP : '0;
      OP_JZ:  e0 = flags_o[0] ? JMP : '0;
      OP_OUT: e0 = bit_mask(AO) | bit_mask(OI);
      OP_HLT: e0 = bit_mask(HLT);
      default: ;
    endcase
    cw = halted ? bit_mask(HLT) : step == SW'(0) ? F0 : step == SW'(1) ? F1 :
         step == SW'(2) ? e0 : step == SW'(3) ? e1 : step == SW'(4) ? e2 : '0;
    nxt = step == SW'(0) ? F1 : step == SW'(1) ? e0 : step == SW'(2) ? e1 : step == SW'(3) ? e2 : '0;
    last = nxt == '0 || step == SW'(MAX_STEPS - 1);
  end
  assign ctrl = CW_W'(cw);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      halted <= cw[HLT];
      step <= cw[HLT] ? step : last ? '0 : step + SW'(1);
    end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: scoreboard bench for ucode_sequencer
module tb_ucode_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic fc = 1'b0, fz = 1'b0;
  logic [15:0] ctrl, ctrl5;
  logic [2:0] step, step5;
  logic halted, halted5;
  logic [1:0] flags, flags5;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] exp_flags = 2'b00;
`ifdef SEQ_COND_JMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif
  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] cw;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  ucode_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c_i(fc), .flag_z_i(fz),
    .ctrl(ctrl), .step(step), .halted(halted), .flags_o(flags)
  );
  ucode_sequencer #(.MAX_STEPS(5)) dut5 (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c_i(fc), .flag_z_i(fz),
    .ctrl(ctrl5), .step(step5), .halted(halted5), .flags_o(flags5)
  );

  function automatic logic [15:0] exe_word(input logic [3:0] op, input int k, input logic [1:0] fl);
    logic [15:0] w [3];
    w = '{16'h0, 16'h0, 16'h0};
    case (op)
      4'h1: w = '{16'h0012, 16'h0084, 16'h0};
      4'h2: w = '{16'h0012, 16'h0404, 16'h8180};
      4'h3: w = '{16'h0012, 16'h0404, 16'h8380};
      4'h4: w = '{16'h0012, 16'h0048, 16'h0};
      4'h5: w[0] = 16'h0090;
      4'h6: w[0] = 16'h4010;
      4'h7: w[0] = (COND && fl[1]) ? 16'h4010 : 16'h0;
      4'h8: w[0] = (COND && fl[0]) ? 16'h4010 : 16'h0;
      4'hE: w[0] = 16'h0840;
      4'hF: w[0] = 16'h0001;
      default: ;
    endcase
    return w[k];
  endfunction

  task automatic run_instr(input string name, input logic [3:0] op, input logic c, input logic z);
    exp_t e;
    logic [15:0] w;
    logic [1:0] nf;
    logic [2:0] end_st;
    opcode = op;
    fc = c;
    fz = z;
    #1;
    q.push_back('{3'd0, 16'h2002});
    q.push_back('{3'd1, 16'h1024});
    for (int k = 0; k < 3; k++) begin
      w = exe_word(op, k, exp_flags);
      if (w == 16'h0) break;
      q.push_back('{3'(k + 2), w});
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (step !== e.st || ctrl !== e.cw) begin
        n_bad++;
        $display("FAIL %s step/ctrl got %0d/%h want %0d/%h", name, step, ctrl, e.st, e.cw);
      end
      nf = (COND && e.cw[15]) ? {c, z} : exp_flags;
      @(posedge clk);
      #1;
      exp_flags = nf;
    end
    end_st = (op == 4'hF) ? 3'd2 : 3'd0;
    n_cmp++;
    if (step !== end_st || halted !== (op == 4'hF) || flags !== exp_flags) begin
      n_bad++;
      $display("FAIL %s_end step/halted/flags got %0d/%b/%b want %0d/%b/%b",
               name, step, halted, flags, end_st, op == 4'hF, exp_flags);
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (step !== 3'd0 || halted !== 1'b0 || flags !== 2'b00 || ctrl !== 16'h2002) begin
      n_bad++;
      $display("FAIL reset got step=%0d halted=%b flags=%b ctrl=%h want 0/0/00/2002", step, halted, flags, ctrl);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd1) begin
      n_bad++;
      $display("FAIL first_edge step got %0d want 1", step);
    end
    @(posedge clk);
    #1;
    exp_flags = 2'b00;
  endtask

  task automatic test_sequence;
    run_instr("lda", 4'h1, 1'b0, 1'b0);
    run_instr("add", 4'h2, 1'b1, 1'b0);
    run_instr("out", 4'hE, 1'b0, 1'b0);
  endtask

  task automatic test_cond_jump;
    run_instr("jc_after_add", 4'h7, 1'b1, 1'b1);
    run_instr("jz_z0", 4'h8, 1'b0, 1'b1);
    run_instr("sub", 4'h3, 1'b0, 1'b1);
    run_instr("jz_z1", 4'h8, 1'b0, 1'b0);
    run_instr("jc_c0", 4'h7, 1'b1, 1'b0);
  endtask

  task automatic test_others;
    run_instr("sta", 4'h4, 1'b0, 1'b0);
    run_instr("ldi", 4'h5, 1'b0, 1'b0);
    run_instr("jmp", 4'h6, 1'b0, 1'b0);
    run_instr("nop", 4'h0, 1'b0, 1'b0);
    run_instr("undef_a", 4'hA, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    opcode = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd2 || ctrl !== 16'h0012) begin
      n_bad++;
      $display("FAIL b2b_lda step/ctrl got %0d/%h want 2/0012", step, ctrl);
    end
    opcode = 4'h5;
    #1;
    n_cmp++;
    if (ctrl !== 16'h0090) begin
      n_bad++;
      $display("FAIL b2b_switch ctrl got %h want 0090", ctrl);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_end step got %0d want 0", step);
    end
  endtask

  task automatic test_mid_reset;
    run_instr("add_pre", 4'h2, 1'b1, 1'b1);
    opcode = 4'h2;
    fc = 1'b0;
    fz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_add step got %0d want 3", step);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (step !== 3'd0 || ctrl !== 16'h2002 || halted !== 1'b0 || flags !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst got step=%0d ctrl=%h halted=%b flags=%b want 0/2002/0/00", step, ctrl, halted, flags);
    end
    opcode = 4'h0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd0 || ctrl !== 16'h2002) begin
      n_bad++;
      $display("FAIL rst_hold step/ctrl got %0d/%h want 0/2002", step, ctrl);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (step !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_release step got %0d want 1", step);
    end
    @(posedge clk);
    #1;
    exp_flags = 2'b00;
  endtask

  task automatic test_halt;
    run_instr("hlt", 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (step !== 3'd2 || ctrl !== 16'h0001 || halted !== 1'b1) begin
        n_bad++;
        $display("FAIL halt_hold%0d got step=%0d ctrl=%h halted=%b want 2/0001/1", i, step, ctrl, halted);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || step !== 3'd0 || ctrl !== 16'h2002) begin
      n_bad++;
      $display("FAIL halt_rst got halted=%b step=%0d ctrl=%h want 0/0/2002", halted, step, ctrl);
    end
    opcode = 4'h0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_flags = 2'b00;
  endtask

  task automatic test_max5;
    logic [2:0] es;
    rst = 1'b1;
    opcode = 4'h9;
    #1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      es = 3'(i % 2);
      n_cmp++;
      if (step5 !== es || step5 > 3'd1 || ctrl5 !== (es == 3'd1 ? 16'h1024 : 16'h2002)) begin
        n_bad++;
        $display("FAIL max5_undef%0d step/ctrl got %0d/%h want %0d", i, step5, ctrl5, es);
      end
      @(posedge clk);
      #1;
    end
    exp_flags = 2'b00;
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_cond_jump;
    test_others;
    test_back_to_back;
    test_mid_reset;
    test_halt;
    test_max5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
